// File: rtl/control_unit_pkg.sv
// control_unit_pkg
// Shared constants and types for the control unit slice.
//   - data-processing opcode values (instr[24:21])
//   - addressing-mode (AM) encodings
//   - condition-code values (instr[31:28])
//   - instruction class values (instr[27:25])
//   - ctrl_t : the bundle of decode controls carried from decode to the bubble mux
//   - ex_t   : the bundle of controls held in the EX pipeline register
package control_unit_pkg;

   // Data-processing opcodes
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_RSB = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_RSC = 4'b0111;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_TEQ = 4'b1001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_CMN = 4'b1011;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_BIC = 4'b1110;
   localparam logic [3:0] OP_MVN = 4'b1111;

   // Addressing-mode encodings
   localparam logic [1:0] AM_IMM_ROT   = 2'b00;
   localparam logic [1:0] AM_REG_OFF   = 2'b01;
   localparam logic [1:0] AM_REG_SHIFT = 2'b10;
   localparam logic [1:0] AM_IMM12     = 2'b11;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Instruction classes
   localparam logic [2:0] CLS_DP_REG = 3'b000;
   localparam logic [2:0] CLS_DP_IMM = 3'b001;
   localparam logic [2:0] CLS_LS_IMM = 3'b010;
   localparam logic [2:0] CLS_LS_REG = 3'b011;
   localparam logic [2:0] CLS_BRANCH = 3'b101;

   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] am;
      logic       s_en;
      logic       load;
      logic       rf;
      logic       size;
      logic       rw;
      logic       en;
      logic       bl;
      logic       b;
   } ctrl_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] am;
      logic       s_en;
      logic       load;
      logic       rf;
      logic       size;
      logic       rw;
      logic       en;
      logic       bl_en;
   } ex_t;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if
// Groups the control unit's instruction/flag inputs and all decode, branch,
// EX-stage and keyword outputs.
//   master : pipeline side, drives instr, S (bubble select), flags {N,Z,C,V}
//   slave  : control unit, drives ID_*, Branch, BranchL, EX_*, keyword
interface control_unit_if;
   logic [31:0] instr;
   logic        S;
   logic [3:0]  flags;

   logic [3:0]  ID_opcode;
   logic [1:0]  ID_AM;
   logic        ID_S_enable;
   logic        ID_load_instr;
   logic        ID_RF_enable;
   logic        ID_Size_enable;
   logic        ID_RW_enable;
   logic        ID_Enable_signal;
   logic        ID_BL_instr;
   logic        ID_B_instr;

   logic        Branch;
   logic        BranchL;

   logic [3:0]  EX_opcode;
   logic [1:0]  EX_AM;
   logic        EX_S_enable;
   logic        EX_load_instr;
   logic        EX_RF_enable;
   logic        EX_Size_enable;
   logic        EX_RW_enable;
   logic        EX_Enable_signal;
   logic        EX_BL_enable;

   logic [47:0] keyword;

   modport master (
      output instr, S, flags,
      input  ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
             ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr,
             ID_B_instr, Branch, BranchL, EX_opcode, EX_AM, EX_S_enable,
             EX_load_instr, EX_RF_enable, EX_Size_enable, EX_RW_enable,
             EX_Enable_signal, EX_BL_enable, keyword
   );

   modport slave (
      input  instr, S, flags,
      output ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
             ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr,
             ID_B_instr, Branch, BranchL, EX_opcode, EX_AM, EX_S_enable,
             EX_load_instr, EX_RF_enable, EX_Size_enable, EX_RW_enable,
             EX_Enable_signal, EX_BL_enable, keyword
   );
endinterface

// File: rtl/control_unit_cond_eval.sv
// cond_eval
// Evaluates an instruction condition field against the current flags.
//   cond      in  4 : instr[31:28]
//   flags     in  4 : {N,Z,C,V}
//   cond_true out 1 : condition holds (1111 never holds)
module cond_eval
   import control_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_true
);

   logic n, z, c, v;
   assign n = flags[3];
   assign z = flags[2];
   assign c = flags[1];
   assign v = flags[0];

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_EQ: cond_true = z;
         COND_NE: cond_true = ~z;
         COND_CS: cond_true = c;
         COND_CC: cond_true = ~c;
         COND_MI: cond_true = n;
         COND_PL: cond_true = ~n;
         COND_VS: cond_true = v;
         COND_VC: cond_true = ~v;
         COND_HI: cond_true = c & ~z;
         COND_LS: cond_true = ~c | z;
         COND_GE: cond_true = (n == v);
         COND_LT: cond_true = (n != v);
         COND_GT: cond_true = ~z & (n == v);
         COND_LE: cond_true = z | (n != v);
         COND_AL: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Instruction decode, bubble mux, branch resolution and ID->EX pipeline
// register for the pipelined core.
//   clk : rising-edge clock
//   R   : asynchronous active-low reset (clears EX_* only)
//   bus : control_unit_if.slave -- instr/S/flags in; ID_*, Branch, BranchL,
//         EX_*, keyword out
// Optional feature: define CU_KEYWORD_EN to drive keyword with the 6-char
// space-padded ASCII mnemonic of instr; otherwise keyword is tied to zero.
module control_unit
   import control_unit_pkg::*;
(
   input  logic           clk,
   input  logic           R,
   control_unit_if.slave  bus
);

   ctrl_t dec;
   ctrl_t id;
   ex_t   ex_q;
   logic  cond_true;

   // Raw decode of the instruction class. The all-zero word is a NOP and
   // overrides the data-processing decode that class 000 would otherwise give.
   always_comb begin
      dec = '0;
      case (bus.instr[27:25])
         CLS_DP_REG, CLS_DP_IMM: begin
            dec.opcode = bus.instr[24:21];
            dec.am     = (bus.instr[27:25] == CLS_DP_REG) ? AM_REG_SHIFT : AM_IMM_ROT;
            // TST/TEQ/CMP/CMN only set flags and never write a register
            if (bus.instr[24:23] == 2'b10) begin
               dec.rf   = 1'b0;
               dec.s_en = 1'b1;
            end else begin
               dec.rf   = 1'b1;
               dec.s_en = bus.instr[20];
            end
         end
         CLS_LS_IMM, CLS_LS_REG: begin
            dec.en     = 1'b1;
            dec.load   = bus.instr[20];
            dec.rf     = bus.instr[20];
            dec.rw     = ~bus.instr[20];
            dec.size   = bus.instr[22];
            // U bit selects whether the offset is added or subtracted
            dec.opcode = bus.instr[23] ? OP_ADD : OP_SUB;
            dec.am     = (bus.instr[27:25] == CLS_LS_IMM) ? AM_IMM12 : AM_REG_OFF;
         end
         CLS_BRANCH: begin
            dec.b  = ~bus.instr[24];
            dec.bl = bus.instr[24];
         end
         default: dec = '0;
      endcase
      if (bus.instr == 32'h0) begin
         dec = '0;
      end
   end

   // Bubble mux: a stall from the forwarding unit squashes every control
   always_comb begin
      id = dec;
      if (bus.S) begin
         id = '0;
      end
   end

   cond_eval u_cond_eval (
      .cond      (bus.instr[31:28]),
      .flags     (bus.flags),
      .cond_true (cond_true)
   );

   assign bus.ID_opcode        = id.opcode;
   assign bus.ID_AM            = id.am;
   assign bus.ID_S_enable      = id.s_en;
   assign bus.ID_load_instr    = id.load;
   assign bus.ID_RF_enable     = id.rf;
   assign bus.ID_Size_enable   = id.size;
   assign bus.ID_RW_enable     = id.rw;
   assign bus.ID_Enable_signal = id.en;
   assign bus.ID_BL_instr      = id.bl;
   assign bus.ID_B_instr       = id.b;

   assign bus.Branch  = cond_true & (id.b | id.bl);
   assign bus.BranchL = cond_true & id.bl;

   // ID->EX pipeline register; the link enable follows the resolved BranchL
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         ex_q <= '0;
      end else begin
         ex_q.opcode <= id.opcode;
         ex_q.am     <= id.am;
         ex_q.s_en   <= id.s_en;
         ex_q.load   <= id.load;
         ex_q.rf     <= id.rf;
         ex_q.size   <= id.size;
         ex_q.rw     <= id.rw;
         ex_q.en     <= id.en;
         ex_q.bl_en  <= bus.BranchL;
      end
   end

   assign bus.EX_opcode        = ex_q.opcode;
   assign bus.EX_AM            = ex_q.am;
   assign bus.EX_S_enable      = ex_q.s_en;
   assign bus.EX_load_instr    = ex_q.load;
   assign bus.EX_RF_enable     = ex_q.rf;
   assign bus.EX_Size_enable   = ex_q.size;
   assign bus.EX_RW_enable     = ex_q.rw;
   assign bus.EX_Enable_signal = ex_q.en;
   assign bus.EX_BL_enable     = ex_q.bl_en;

`ifdef CU_KEYWORD_EN
   logic [47:0] kw;

   // Mnemonic follows the raw instruction, independent of the bubble select
   always_comb begin
      kw = "???   ";
      if (bus.instr == 32'h0) begin
         kw = "NOP   ";
      end else begin
         case (bus.instr[27:25])
            CLS_DP_REG, CLS_DP_IMM: begin
               case (bus.instr[24:21])
                  OP_AND:  kw = "AND   ";
                  OP_EOR:  kw = "EOR   ";
                  OP_SUB:  kw = "SUB   ";
                  OP_RSB:  kw = "RSB   ";
                  OP_ADD:  kw = "ADD   ";
                  OP_ADC:  kw = "ADC   ";
                  OP_SBC:  kw = "SBC   ";
                  OP_RSC:  kw = "RSC   ";
                  OP_TST:  kw = "TST   ";
                  OP_TEQ:  kw = "TEQ   ";
                  OP_CMP:  kw = "CMP   ";
                  OP_CMN:  kw = "CMN   ";
                  OP_ORR:  kw = "ORR   ";
                  OP_MOV:  kw = "MOV   ";
                  OP_BIC:  kw = "BIC   ";
                  default: kw = "MVN   ";
               endcase
            end
            CLS_LS_IMM, CLS_LS_REG: begin
               case ({bus.instr[20], bus.instr[22]})
                  2'b10:   kw = "LDR   ";
                  2'b11:   kw = "LDRB  ";
                  2'b00:   kw = "STR   ";
                  default: kw = "STRB  ";
               endcase
            end
            CLS_BRANCH: kw = bus.instr[24] ? "BL    " : "B     ";
            default:    kw = "???   ";
         endcase
      end
   end

   assign bus.keyword = kw;
`else
   assign bus.keyword = 48'h0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Randomized scoreboard bench for control_unit. The driver applies one
// instruction per cycle on the falling edge and queues the reference result;
// the monitor pops one entry after each rising edge and compares both the
// combinational outputs and the freshly loaded EX register.
module tb_control_unit;

   logic clk;
   logic R;

   control_unit_if bus ();

   control_unit dut (
      .clk (clk),
      .R   (R),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  opcode;
      logic [1:0]  am;
      logic        s_en;
      logic        load;
      logic        rf;
      logic        size;
      logic        rw;
      logic        en;
      logic        bl;
      logic        b;
      logic        branch;
      logic        branchl;
      logic [47:0] kw;
   } exp_t;

   exp_t sbq[$];
   int compared = 0;
   int mismatched = 0;

   task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [47:0] pad(input string s);
      logic [47:0] r;
      r = {6{8'h20}};
      for (int i = 0; i < s.len(); i++) r[47-8*i -: 8] = s[i];
      return r;
   endfunction

`ifdef CU_KEYWORD_EN
   function automatic logic [47:0] expKeyword(input logic [31:0] ins);
      string dp[16];
      dp = '{"AND","EOR","SUB","RSB","ADD","ADC","SBC","RSC",
             "TST","TEQ","CMP","CMN","ORR","MOV","BIC","MVN"};
      if (ins == 32'h0) return pad("NOP");
      case (ins[27:25])
         3'd0, 3'd1: return pad(dp[ins[24:21]]);
         3'd2, 3'd3: return pad({ins[20] ? "LDR" : "STR", ins[22] ? "B" : ""});
         3'd5:       return pad(ins[24] ? "BL" : "B");
         default:    return pad("???");
      endcase
   endfunction
`else
   function automatic logic [47:0] expKeyword(input logic [31:0] ins);
      return (ins == 32'hFFFF_FFFF) ? 48'h0 : 48'h0;
   endfunction
`endif

   // Conditions come in complementary pairs: even code = base test,
   // odd code = its negation; pair 7 is AL (1110) / never (1111).
   function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return cond[0] ? !base : base;
   endfunction

   function automatic exp_t model(input logic [31:0] ins, input logic s, input logic [3:0] f);
      exp_t e;
      int   cls;
      int   op;
      logic ct;
      e = '{default: '0};
      cls = int'(ins[27:25]);
      op  = int'(ins[24:21]);
      if (ins != 32'h0) begin
         if (cls == 0 || cls == 1) begin
            e.opcode = ins[24:21];
            e.am     = (cls == 0) ? 2'd2 : 2'd0;
            if (op >= 8 && op <= 11) begin
               e.rf = 1'b0; e.s_en = 1'b1;
            end else begin
               e.rf = 1'b1; e.s_en = ins[20];
            end
         end else if (cls == 2 || cls == 3) begin
            e.en     = 1'b1;
            e.load   = ins[20];
            e.rf     = ins[20];
            e.rw     = !ins[20];
            e.size   = ins[22];
            e.opcode = ins[23] ? 4'd4 : 4'd2;
            e.am     = (cls == 2) ? 2'd3 : 2'd1;
         end else if (cls == 5) begin
            e.b  = !ins[24];
            e.bl = ins[24];
         end
      end
      if (s) begin
         e.opcode = '0; e.am = '0; e.s_en = 0; e.load = 0; e.rf = 0;
         e.size = 0; e.rw = 0; e.en = 0; e.bl = 0; e.b = 0;
      end
      ct = condHolds(ins[31:28], f);
      e.branch  = ct && (e.b || e.bl);
      e.branchl = ct && e.bl;
      e.kw      = expKeyword(ins);
      return e;
   endfunction

   task automatic applyStimulus(input logic [31:0] ins, input logic s, input logic [3:0] f);
      @(negedge clk);
      bus.instr = ins;
      bus.S     = s;
      bus.flags = f;
      sbq.push_back(model(ins, s, f));
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 19);
      if (k == 0) return 32'h0;
      if (k <= 5)       r[27:25] = 3'b000;
      else if (k <= 9)  r[27:25] = 3'b001;
      else if (k <= 12) r[27:25] = 3'b010;
      else if (k <= 15) r[27:25] = 3'b011;
      else if (k <= 17) r[27:25] = 3'b101;
      return r;
   endfunction

   // Monitor: every rising edge presents one decoded instruction and its EX copy
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (R === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("ID_opcode", 48'(bus.ID_opcode), 48'(e.opcode));
            checkOutput("ID_AM", 48'(bus.ID_AM), 48'(e.am));
            checkOutput("ID_S_enable", 48'(bus.ID_S_enable), 48'(e.s_en));
            checkOutput("ID_load_instr", 48'(bus.ID_load_instr), 48'(e.load));
            checkOutput("ID_RF_enable", 48'(bus.ID_RF_enable), 48'(e.rf));
            checkOutput("ID_Size_enable", 48'(bus.ID_Size_enable), 48'(e.size));
            checkOutput("ID_RW_enable", 48'(bus.ID_RW_enable), 48'(e.rw));
            checkOutput("ID_Enable_signal", 48'(bus.ID_Enable_signal), 48'(e.en));
            checkOutput("ID_BL_instr", 48'(bus.ID_BL_instr), 48'(e.bl));
            checkOutput("ID_B_instr", 48'(bus.ID_B_instr), 48'(e.b));
            checkOutput("Branch", 48'(bus.Branch), 48'(e.branch));
            checkOutput("BranchL", 48'(bus.BranchL), 48'(e.branchl));
            checkOutput("EX_opcode", 48'(bus.EX_opcode), 48'(e.opcode));
            checkOutput("EX_AM", 48'(bus.EX_AM), 48'(e.am));
            checkOutput("EX_S_enable", 48'(bus.EX_S_enable), 48'(e.s_en));
            checkOutput("EX_load_instr", 48'(bus.EX_load_instr), 48'(e.load));
            checkOutput("EX_RF_enable", 48'(bus.EX_RF_enable), 48'(e.rf));
            checkOutput("EX_Size_enable", 48'(bus.EX_Size_enable), 48'(e.size));
            checkOutput("EX_RW_enable", 48'(bus.EX_RW_enable), 48'(e.rw));
            checkOutput("EX_Enable_signal", 48'(bus.EX_Enable_signal), 48'(e.en));
            checkOutput("EX_BL_enable", 48'(bus.EX_BL_enable), 48'(e.branchl));
            checkOutput("keyword", bus.keyword, e.kw);
         end
      end
   end

   task automatic checkExZero(input string tag);
      checkOutput({tag, " EX_opcode"}, 48'(bus.EX_opcode), 48'h0);
      checkOutput({tag, " EX_AM"}, 48'(bus.EX_AM), 48'h0);
      checkOutput({tag, " EX_S_enable"}, 48'(bus.EX_S_enable), 48'h0);
      checkOutput({tag, " EX_load_instr"}, 48'(bus.EX_load_instr), 48'h0);
      checkOutput({tag, " EX_RF_enable"}, 48'(bus.EX_RF_enable), 48'h0);
      checkOutput({tag, " EX_Size_enable"}, 48'(bus.EX_Size_enable), 48'h0);
      checkOutput({tag, " EX_RW_enable"}, 48'(bus.EX_RW_enable), 48'h0);
      checkOutput({tag, " EX_Enable_signal"}, 48'(bus.EX_Enable_signal), 48'h0);
      checkOutput({tag, " EX_BL_enable"}, 48'(bus.EX_BL_enable), 48'h0);
   endtask

   initial begin
      exp_t e;
      logic [31:0] ins;
      R = 1'b0;
      bus.instr = 32'hE591_2000;
      bus.S     = 1'b0;
      bus.flags = 4'b0000;
      #12;
      checkExZero("reset");
      @(negedge clk);
      R = 1'b1;

      // Directed vectors
      applyStimulus(32'hE281_1005, 1'b0, 4'b0000);
      applyStimulus(32'hE591_2000, 1'b0, 4'b0000);
      applyStimulus(32'hE151_0002, 1'b0, 4'b0000);
      applyStimulus(32'h0A00_0003, 1'b0, 4'b0100);
      applyStimulus(32'h0A00_0003, 1'b0, 4'b0000);
      applyStimulus(32'hEB00_0002, 1'b0, 4'($urandom));
      applyStimulus(32'hE591_2000, 1'b1, 4'b0000);
      applyStimulus(32'h0000_0000, 1'b0, 4'b1111);
      applyStimulus(32'hF800_0000, 1'b0, 4'b1111);
      applyStimulus(32'hFB00_0000, 1'b0, 4'b1111);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         ins = randInstr();
         applyStimulus(ins, ($urandom_range(0, 4) == 0), 4'($urandom));
      end

      // Mid-operation reset after a branch-and-link has reached EX
      applyStimulus(32'hEB00_0002, 1'b0, 4'b0000);
      @(posedge clk);
      #3;
      R = 1'b0;
      #1;
      checkExZero("async reset");
      e = model(32'hEB00_0002, 1'b0, 4'b0000);
      checkOutput("reset Branch", 48'(bus.Branch), 48'(e.branch));
      checkOutput("reset BranchL", 48'(bus.BranchL), 48'(e.branchl));
      checkOutput("reset ID_BL_instr", 48'(bus.ID_BL_instr), 48'(e.bl));
      @(posedge clk);
      #1;
      checkExZero("held reset");
      @(negedge clk);
      R = 1'b1;

      applyStimulus(32'hE281_1005, 1'b0, 4'b0000);
      for (int i = 0; i < 20; i++) begin
         ins = randInstr();
         applyStimulus(ins, 1'b0, 4'($urandom));
      end

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      compared++;
      if (sbq.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; R in 1, reset, asynchronous, active-low.
REQ-002 SHALL have ports: instr in 32, IF/ID instruction; S in 1, bubble select from forwarding unit; flags in 4, {N,Z,C,V} selected flags.
REQ-003 SHALL have decode outputs, all combinational: ID_opcode out 4; ID_AM out 2; ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr out 1 each.
REQ-004 SHALL have outputs Branch and BranchL, out 1 each, combinational.
REQ-005 SHALL have registered outputs EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable, EX_RW_enable, EX_Enable_signal and EX_BL_enable.
REQ-006 SHALL have output keyword, out 48, 6-char ASCII mnemonic (see REQ-020).

Function
REQ-007 Decode SHALL use instr[27:25]:
- 000: data-proc, register shift, AM=10.
- 001: data-proc, immediate rotate, AM=00.
- 010: load/store, imm12 offset, AM=11.
- 011: load/store, register offset, AM=01.
- 101: branch.
- Others: all controls 0.
REQ-008 Data-proc SHALL set: opcode=instr[24:21]; S_enable=instr[20]; RF_enable=1 except opcodes 1000-1011 (TST/TEQ/CMP/CMN), which give RF_enable=0 and S_enable=1.
REQ-009 Data-proc SHALL set load, Size, RW, Enable, B and BL to 0.
REQ-010 Load/store SHALL set: Enable_signal=1; load_instr=instr[20]; RF_enable=instr[20]; RW_enable=~instr[20] (1=write); Size_enable=instr[22] (1=byte); S_enable=0.
REQ-011 Load/store opcode SHALL be 0100 (ADD) when instr[23]=1, else 0010 (SUB).
REQ-012 Branch SHALL set B_instr=~instr[24] and BL_instr=instr[24]; all other controls 0.
REQ-013 instr==32'h0 SHALL decode as NOP: all controls 0.
REQ-014 Bubble mux: S=1 SHALL force every ID_* output to 0; S=0 passes the decode.
REQ-015 Conditions on instr[31:28]: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 0.
REQ-016 Branch SHALL equal cond_true&(ID_B_instr|ID_BL_instr); BranchL SHALL equal cond_true&ID_BL_instr, using post-bubble values.
REQ-017 Pipeline register: each rising clk SHALL load EX_* from the matching ID_* signal, and EX_BL_enable from BranchL; latency 1 cycle.

Reset
REQ-018 R=0 SHALL asynchronously clear all EX_* outputs to 0, and they SHALL hold 0 while R=0.
REQ-019 Combinational outputs SHALL be unaffected by R.

Configuration
REQ-020 With macro CU_KEYWORD_EN defined, keyword SHALL be the space-padded mnemonic: "AND".."MVN", "LDR", "LDRB", "STR", "STRB", "B", "BL", "NOP", or "???" for undefined.
REQ-021 Without CU_KEYWORD_EN, keyword SHALL be tied to 48'h0 and no mnemonic logic SHALL be synthesized.

Structure
REQ-022 A shared package SHALL hold the opcode constants, AM encodings, condition-code constants and the instr[27:25] class constants.
REQ-023 The condition evaluator SHALL be one sub-module, cond_eval (cond, flags -> cond_true); decode, bubble mux and EX register stay in the top.

Verification
REQ-024 Data-proc immediate: instr=E2811005, S=0 -> opcode 0100, AM 00, RF 1, S_enable 0, keyword "ADD".
REQ-025 Load: instr=E5912000 -> load 1, RF 1, Enable 1, RW 0, Size 0, opcode 0100, AM 11.
REQ-026 Compare: instr=E1510002 -> opcode 1010, S_enable 1, RF 0.
REQ-027 Conditional branch, instr=0A000003:
- flags=0100 -> Branch 1, BranchL 0.
- flags=0000 -> Branch 0.
REQ-028 Branch-and-link: instr=EB000002, any flags -> Branch 1, BranchL 1; next clk -> EX_BL_enable 1.
REQ-029 Bubble: S=1 with instr=E5912000 -> all ID_* 0 and Branch 0; next clk -> EX_* 0.
REQ-030 Reset: R=0 mid-operation -> EX_* 0 immediately, without waiting for clk.
